// File: rtl/alu_seq_exec.sv
// Sequential RV32I EX-stage ALU with valid/ready handshakes on both sides.
// Define ALU_SEQ_FAST_SHIFT_EN to use a single-cycle barrel shifter instead of the iterative one.
module alu_seq_exec #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            op_err
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_SLL   = 4'b0010;
    localparam logic [3:0] OP_SLT   = 4'b0011;
    localparam logic [3:0] OP_SLTU  = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_OR    = 4'b1000;
    localparam logic [3:0] OP_AND   = 4'b1001;
    localparam logic [3:0] OP_LUI   = 4'b1010;
    localparam logic [3:0] OP_AUIPC = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t              state_r, state_s;
    logic [XLEN-1:0]     result_r, result_s;
    logic                zero_r, zero_s;
    logic                err_r, err_s;
    logic [XLEN-1:0]     shreg_r, shreg_s;
    logic [SHAMT_W-1:0]  cnt_r, cnt_s;
    logic [3:0]          sop_r, sop_s;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [SHAMT_W-1:0]  shamt_s;

    // Full single-cycle ALU; shifts here act as a barrel shifter (also covers shamt=0).
    function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
        case (op)
            OP_ADD:   alu_calc = a + b;
            OP_SUB:   alu_calc = a - b;
            OP_SLL:   alu_calc = a << sh;
            OP_SLT:   alu_calc = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  alu_calc = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:   alu_calc = a ^ b;
            OP_SRL:   alu_calc = a >> sh;
            OP_SRA:   alu_calc = $unsigned($signed(a) >>> sh);
            OP_OR:    alu_calc = a | b;
            OP_AND:   alu_calc = a & b;
            OP_LUI:   alu_calc = b;
            OP_AUIPC: alu_calc = a + b;
            default:  alu_calc = {XLEN{1'b0}};
        endcase
    endfunction

    // One step of the iterative shifter.
    function automatic logic [XLEN-1:0] shift_one(input logic [3:0] op,
                                                  input logic [XLEN-1:0] v);
        case (op)
            OP_SLL:  shift_one = {v[XLEN-2:0], 1'b0};
            OP_SRL:  shift_one = {1'b0, v[XLEN-1:1]};
            OP_SRA:  shift_one = {v[XLEN-1], v[XLEN-1:1]};
            default: shift_one = v;
        endcase
    endfunction

    assign shamt_s = src_b[SHAMT_W-1:0];

    // Next-state and next-datapath logic.
    always_comb begin
        state_s  = state_r;
        result_s = result_r;
        zero_s   = zero_r;
        err_s    = err_r;
        shreg_s  = shreg_r;
        cnt_s    = cnt_r;
        sop_s    = sop_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_FAST_SHIFT_EN
                    result_s = alu_calc(alu_op, src_a, src_b);
                    zero_s   = (result_s == {XLEN{1'b0}});
                    err_s    = (alu_op[3:2] == 2'b11);
                    state_s  = ST_DONE;
`else
                    if ((alu_op == OP_SLL || alu_op == OP_SRL || alu_op == OP_SRA) &&
                        (shamt_s != {SHAMT_W{1'b0}})) begin
                        shreg_s = src_a;
                        cnt_s   = shamt_s;
                        sop_s   = alu_op;
                        state_s = ST_SHIFT;
                    end else begin
                        result_s = alu_calc(alu_op, src_a, src_b);
                        zero_s   = (result_s == {XLEN{1'b0}});
                        err_s    = (alu_op[3:2] == 2'b11);
                        state_s  = ST_DONE;
                    end
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shreg_s = shift_one(sop_r, shreg_r);
                cnt_s   = cnt_r - SHAMT_W'(1);
                if (cnt_r == SHAMT_W'(1)) begin
                    result_s = shreg_s;
                    zero_s   = (shreg_s == {XLEN{1'b0}});
                    err_s    = 1'b0;
                    state_s  = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            result_r    <= {XLEN{1'b0}};
            zero_r      <= 1'b0;
            err_r       <= 1'b0;
            shreg_r     <= {XLEN{1'b0}};
            cnt_r       <= {SHAMT_W{1'b0}};
            sop_r       <= 4'b0000;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            result_r    <= result_s;
            zero_r      <= zero_s;
            err_r       <= err_s;
            shreg_r     <= shreg_s;
            cnt_r       <= cnt_s;
            sop_r       <= sop_s;
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign op_err    = err_r;

endmodule
